// File: rtl/rf_wb_pkg.sv
// Shared widths and payload type for the register-file writeback path.
package rf_wb_pkg;

    localparam int unsigned RF_KEY_W    = 5;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 32;

    localparam logic [RF_KEY_W-1:0] RF_ZERO_KEY = '0;

    typedef struct packed {
        logic [RF_KEY_W-1:0]  key;
        logic [RF_DATA_W-1:0] value;
    } rf_write_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer holding load results until they win the write port.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = rf_write_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// Serialises ALU and load results onto the single register-file write port
// and tracks pending writes in a 32-entry busy scoreboard.
module rf_writeback_unit
    import rf_wb_pkg::*;
#(
    parameter int unsigned LD_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alu_valid,
    output logic                           alu_ready,
    input  logic [RF_KEY_W-1:0]            alu_key,
    input  logic [RF_DATA_W-1:0]           alu_value,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [RF_KEY_W-1:0]            ld_key,
    input  logic [RF_DATA_W-1:0]           ld_value,
    input  logic                           sb_set_enable,
    input  logic [RF_KEY_W-1:0]            sb_set_key,
    input  logic [RF_KEY_W-1:0]            sb_query1_key,
    input  logic [RF_KEY_W-1:0]            sb_query2_key,
    output logic                           sb_query1_busy,
    output logic                           sb_query2_busy,
    output logic                           rf_portD_enable,
    output logic [RF_KEY_W-1:0]            rf_portD_key,
    output logic [RF_DATA_W-1:0]           rf_portD_value,
    output logic [$clog2(LD_FIFO_DEPTH):0] ld_fifo_count
);

    rf_write_t              ld_write;
    rf_write_t              fifo_head;
    rf_write_t              wr_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   wr_en;
    logic [RF_NUM_REGS-1:0] busy_q;
    logic [RF_NUM_REGS-1:0] busy_d;

    assign alu_ready = !fifo_full;
    assign ld_ready  = !fifo_full;
    assign fifo_push = ld_valid && ld_ready && (ld_key != RF_ZERO_KEY);
    assign ld_write  = {ld_key, ld_value};

    rf_wb_fifo #(
        .DEPTH (LD_FIFO_DEPTH),
        .T     (rf_write_t)
    ) u_ld_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (ld_write),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (ld_fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Port arbitration: a full FIFO drains first, otherwise the ALU wins.
    always_comb begin
        wr_en    = 1'b0;
        fifo_pop = 1'b0;
        wr_data  = fifo_head;
        if (fifo_full) begin
            wr_en    = 1'b1;
            fifo_pop = 1'b1;
        end else if (alu_valid && (alu_key != RF_ZERO_KEY)) begin
            wr_en   = 1'b1;
            wr_data = {alu_key, alu_value};
        end else if (!fifo_empty) begin
            wr_en    = 1'b1;
            fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_portD_enable <= 1'b0;
            rf_portD_key    <= '0;
            rf_portD_value  <= '0;
        end else begin
            rf_portD_enable <= wr_en;
            if (wr_en) begin
                rf_portD_key   <= wr_data.key;
                rf_portD_value <= wr_data.value;
            end
        end
    end

    // Set is applied after clear so a same-cycle collision stays busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)         busy_d[wr_data.key] = 1'b0;
        if (sb_set_enable) busy_d[sb_set_key]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign sb_query1_busy = busy_q[sb_query1_key];
    assign sb_query2_busy = busy_q[sb_query2_key];

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Scoreboard bench for rf_writeback_unit: expected writes are queued on
// handshake and matched against rf_portD as writes appear.
module tb_rf_writeback_unit;
    import rf_wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_key;
    logic [31:0] alu_value;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_key;
    logic [31:0] ld_value;
    logic        sb_set_enable;
    logic [4:0]  sb_set_key, sb_query1_key, sb_query2_key;
    logic        sb_query1_busy, sb_query2_busy;
    logic        rf_portD_enable;
    logic [4:0]  rf_portD_key;
    logic [31:0] rf_portD_value;
    logic [2:0]  ld_fifo_count;

    typedef struct {
        logic [4:0]  key;
        logic [31:0] value;
        int          due;
    } alu_exp_t;

    alu_exp_t  alu_q[$];
    rf_write_t ld_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;

    rf_writeback_unit #(.LD_FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_key         (alu_key),
        .alu_value       (alu_value),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_key          (ld_key),
        .ld_value        (ld_value),
        .sb_set_enable   (sb_set_enable),
        .sb_set_key      (sb_set_key),
        .sb_query1_key   (sb_query1_key),
        .sb_query2_key   (sb_query2_key),
        .sb_query1_busy  (sb_query1_busy),
        .sb_query2_busy  (sb_query2_busy),
        .rf_portD_enable (rf_portD_enable),
        .rf_portD_key    (rf_portD_key),
        .rf_portD_value  (rf_portD_value),
        .ld_fifo_count   (ld_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write monitor: an accepted ALU result must appear exactly one cycle
    // later; any other write must be the oldest outstanding load.
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_q.size() > 0 && alu_q[0].due == cyc) begin
                n_checks++;
                if (rf_portD_enable !== 1'b1 || rf_portD_key !== alu_q[0].key ||
                    rf_portD_value !== alu_q[0].value) begin
                    n_fail++;
                    $display("FAIL alu_write: got en=%b key=%0d val=%h, expected en=1 key=%0d val=%h",
                             rf_portD_enable, rf_portD_key, rf_portD_value, alu_q[0].key, alu_q[0].value);
                end
                void'(alu_q.pop_front());
            end else if (rf_portD_enable === 1'b1) begin
                n_checks++;
                if (ld_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got key=%0d val=%h, expected no write",
                             rf_portD_key, rf_portD_value);
                end else begin
                    if (rf_portD_key !== ld_q[0].key || rf_portD_value !== ld_q[0].value) begin
                        n_fail++;
                        $display("FAIL load_order: got key=%0d val=%h, expected key=%0d val=%h",
                                 rf_portD_key, rf_portD_value, ld_q[0].key, ld_q[0].value);
                    end
                    void'(ld_q.pop_front());
                end
            end
            if (alu_valid && alu_ready && alu_key != 5'd0)
                alu_q.push_back('{key: alu_key, value: alu_value, due: cyc + 1});
            if (ld_valid && ld_ready && ld_key != 5'd0)
                ld_q.push_back({ld_key, ld_value});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_key = '0; alu_value = '0;
        ld_valid = 1'b0;  ld_key = '0;  ld_value = '0;
        sb_set_enable = 1'b0; sb_set_key = '0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while ((ld_fifo_count != 0 || ld_q.size() != 0 || alu_q.size() != 0) && k < max_cycles) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= max_cycles) begin
            n_fail++;
            $display("FAIL drain_timeout: count=%0d ld_q=%0d alu_q=%0d after %0d cycles, expected all 0",
                     ld_fifo_count, ld_q.size(), alu_q.size(), k);
        end
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        sb_query1_key = 5'd1; sb_query2_key = 5'd31;
        reset = 1'b1;
        #3;
        n_checks++;
        if (rf_portD_enable !== 1'b0 || ld_fifo_count !== 3'd0 || ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_during: got en=%b count=%0d ld_ready=%b alu_ready=%b, expected 0 0 1 1",
                     rf_portD_enable, ld_fifo_count, ld_ready, alu_ready);
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (rf_portD_enable !== 1'b0 || rf_portD_key !== 5'd0 || rf_portD_value !== 32'd0 ||
            sb_query1_busy !== 1'b0 || sb_query2_busy !== 1'b0 || ld_fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_after: got en=%b key=%0d val=%h busy=%b%b count=%0d, expected all 0",
                     rf_portD_enable, rf_portD_key, rf_portD_value, sb_query1_busy, sb_query2_busy, ld_fifo_count);
        end
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_key = 5'd5; alu_value = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        n_checks++;
        if (rf_portD_enable !== 1'b1 || rf_portD_key !== 5'd5 || rf_portD_value !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_latency: got en=%b key=%0d val=%h, expected 1 5 deadbeef",
                     rf_portD_enable, rf_portD_key, rf_portD_value);
        end
        step();
        n_checks++;
        if (rf_portD_enable !== 1'b0 || rf_portD_key !== 5'd5 || rf_portD_value !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_hold: got en=%b key=%0d val=%h, expected 0 5 deadbeef",
                     rf_portD_enable, rf_portD_key, rf_portD_value);
        end
    endtask

    task automatic test_busy();
        sb_query1_key = 5'd7; sb_query2_key = 5'd0;
        sb_set_enable = 1'b1; sb_set_key = 5'd7;
        step();
        sb_set_enable = 1'b0;
        n_checks++;
        if (sb_query1_busy !== 1'b1 || sb_query2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_set: got q7=%b q0=%b, expected 1 0", sb_query1_busy, sb_query2_busy);
        end
        ld_valid = 1'b1; ld_key = 5'd7; ld_value = 32'h1234;
        step();
        ld_valid = 1'b0;
        n_checks++;
        if (sb_query1_busy !== 1'b1 || rf_portD_enable !== 1'b0 || ld_fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL busy_n1: got busy=%b en=%b count=%0d, expected 1 0 1",
                     sb_query1_busy, rf_portD_enable, ld_fifo_count);
        end
        step();
        n_checks++;
        if (rf_portD_enable !== 1'b1 || rf_portD_key !== 5'd7 || rf_portD_value !== 32'h1234 ||
            sb_query1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_n2: got en=%b key=%0d val=%h busy=%b, expected 1 7 00001234 0",
                     rf_portD_enable, rf_portD_key, rf_portD_value, sb_query1_busy);
        end
        ld_valid = 1'b1; ld_key = 5'd7; ld_value = 32'h5678;
        step();
        ld_valid = 1'b0;
        sb_set_enable = 1'b1; sb_set_key = 5'd7;
        step();
        sb_set_enable = 1'b0;
        n_checks++;
        if (rf_portD_enable !== 1'b1 || rf_portD_key !== 5'd7 || sb_query1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: got en=%b key=%0d busy=%b, expected 1 7 1",
                     rf_portD_enable, rf_portD_key, sb_query1_busy);
        end
        step();
        n_checks++;
        if (sb_query1_busy !== 1'b1 || rf_portD_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL set_wins_hold: got busy=%b en=%b, expected 1 0", sb_query1_busy, rf_portD_enable);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ld_ready !== 1'b1 || ld_fifo_count !== 3'(i)) begin
                n_fail++;
                $display("FAIL b2b_fill: got ready=%b count=%0d, expected 1 %0d", ld_ready, ld_fifo_count, i);
            end
            ld_valid = 1'b1; ld_key = 5'(20 + i); ld_value = 32'hA000 + 32'(i);
            alu_valid = 1'b1; alu_key = 5'(10 + i); alu_value = 32'hB000 + 32'(i);
            step();
        end
        ld_valid = 1'b0;
        alu_key = 5'd14; alu_value = 32'hB004;
        n_checks++;
        if (ld_fifo_count !== 3'd4 || ld_ready !== 1'b0 || alu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got count=%0d ld_ready=%b alu_ready=%b, expected 4 0 0",
                     ld_fifo_count, ld_ready, alu_ready);
        end
        step();
        n_checks++;
        if (ld_fifo_count !== 3'd3 || alu_ready !== 1'b1 || rf_portD_enable !== 1'b1 || rf_portD_key !== 5'd20) begin
            n_fail++;
            $display("FAIL b2b_drain: got count=%0d alu_ready=%b en=%b key=%0d, expected 3 1 1 20",
                     ld_fifo_count, alu_ready, rf_portD_enable, rf_portD_key);
        end
        step();
        alu_valid = 1'b0;
        n_checks++;
        if (rf_portD_key !== 5'd14 || ld_fifo_count !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_alu_resume: got key=%0d count=%0d, expected 14 3", rf_portD_key, ld_fifo_count);
        end
        wait_drain(20);
    endtask

    task automatic test_alu_key0();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_key = 5'(24 + i); ld_value = 32'hC000 + 32'(i);
            alu_valid = 1'b1; alu_key = 5'd11; alu_value = 32'hD000 + 32'(i);
            step();
        end
        ld_key = 5'd0; ld_value = 32'hBAD0;
        alu_key = 5'd0; alu_value = 32'hFFFFFFFF;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        n_checks++;
        if (rf_portD_enable !== 1'b1 || rf_portD_key !== 5'd24 || ld_fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL key0_slot: got en=%b key=%0d count=%0d, expected 1 24 1",
                     rf_portD_enable, rf_portD_key, ld_fifo_count);
        end
        wait_drain(20);
        ld_valid = 1'b1; ld_key = 5'd0; ld_value = 32'hBAD1;
        step();
        ld_valid = 1'b0;
        n_checks++;
        if (ld_fifo_count !== 3'd0 || rf_portD_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL key0_load_drop: got count=%0d en=%b, expected 0 0", ld_fifo_count, rf_portD_enable);
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int k    = 0;
        ld_key = 5'd1; ld_value = 32'hE000;
        while (sent < 10 && k < 200) begin
            if (!(alu_valid && !alu_ready)) begin
                alu_valid = ($urandom_range(1, 0) == 1);
                alu_key   = 5'($urandom_range(31, 1));
                alu_value = $urandom;
            end
            ld_valid = ($urandom_range(3, 0) != 0);
            #0;
            if (ld_valid && ld_ready) sent++;
            step();
            k++;
            if (ld_valid && sent < 10) begin
                ld_key = 5'(sent % 31 + 1); ld_value = 32'hE000 + 32'(sent);
            end
            n_checks++;
            if (ld_fifo_count > 3'd4) begin
                n_fail++;
                $display("FAIL wrap_count: got count=%0d, expected <= 4", ld_fifo_count);
            end
        end
        n_checks++;
        if (sent != 10) begin
            n_fail++;
            $display("FAIL wrap_sent: got %0d loads accepted, expected 10", sent);
        end
        idle_inputs();
        wait_drain(40);
    endtask

    task automatic test_reset_mid();
        sb_query1_key = 5'd2; sb_query2_key = 5'd3;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_key = 5'(16 + i); ld_value = 32'hF000 + 32'(i);
            alu_valid = 1'b1; alu_key = 5'd12; alu_value = 32'h1200 + 32'(i);
            sb_set_enable = 1'b1; sb_set_key = 5'(1 + i);
            step();
        end
        ld_valid = 1'b0; sb_set_enable = 1'b0;
        n_checks++;
        if (ld_fifo_count !== 3'd3 || sb_query1_busy !== 1'b1 || sb_query2_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got count=%0d busy2=%b busy3=%b, expected 3 1 1",
                     ld_fifo_count, sb_query1_busy, sb_query2_busy);
        end
        #3;
        reset = 1'b1;
        alu_valid = 1'b0;
        #1;
        alu_q.delete();
        ld_q.delete();
        n_checks++;
        if (ld_fifo_count !== 3'd0 || sb_query1_busy !== 1'b0 || sb_query2_busy !== 1'b0 ||
            rf_portD_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got count=%0d busy2=%b busy3=%b en=%b, expected 0 0 0 0",
                     ld_fifo_count, sb_query1_busy, sb_query2_busy, rf_portD_enable);
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (ld_fifo_count !== 3'd0 || rf_portD_enable !== 1'b0 || ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release: got count=%0d en=%b ready=%b, expected 0 0 1",
                     ld_fifo_count, rf_portD_enable, ld_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_write();
        test_busy();
        test_back_to_back();
        test_alu_key0();
        test_wrap();
        test_reset_mid();
        n_checks++;
        if (ld_q.size() != 0 || alu_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queues: got ld_q=%0d alu_q=%0d, expected 0 0", ld_q.size(), alu_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
